// File: rtl/sseg_time_mux.sv
// Two-digit multiplexed seven-segment driver for the 0-59 stopwatch.
// Captures {units,tens} once per frame, supports lap hold, blanks the leading zero and shows "E" for bad codes.
module sseg_time_mux #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned BLANK_CYC       = 16,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1,
  parameter bit          DIG_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LEAD_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] units,
  input  logic [2:0] tens,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int unsigned   CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  // XOR masks turn an active-high "lit" pattern into the pin polarity
  localparam logic [6:0]    SEG_XOR   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic          DP_XOR    = SEG_ACTIVE_LOW;
  localparam logic [1:0]    AN_XOR    = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0]    PAT_E     = 7'h79;

  logic [CW-1:0] cnt_r;
  logic          slot_r;
  logic [3:0]    shadow_u_r;
  logic [2:0]    shadow_t_r;
  logic [6:0]    seg_s;
  logic [1:0]    an_s;
  logic          dp_s;
  logic [6:0]    units_pat_s;
  logic [6:0]    tens_pat_s;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = PAT_E;
    endcase
  endfunction

  function automatic logic [6:0] tens_pattern(input logic [2:0] t);
    if (BLANK_LEAD_ZERO && (t == 3'd0)) begin
      tens_pattern = 7'h00;
    end else if (t > 3'd5) begin
      tens_pattern = PAT_E;
    end else begin
      tens_pattern = seg_pattern({1'b0, t});
    end
  endfunction

  // Slot timing, frame-end pulse and once-per-frame capture of the digits
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= '0;
      slot_r     <= 1'b0;
      shadow_u_r <= 4'd0;
      shadow_t_r <= 3'd0;
      frame_done <= 1'b0;
    end else if (!en) begin
      cnt_r      <= '0;
      slot_r     <= 1'b0;
      frame_done <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r      <= '0;
      slot_r     <= ~slot_r;
      frame_done <= slot_r;
      if (slot_r && !hold) begin
        shadow_u_r <= units;
        shadow_t_r <= tens;
      end
    end else begin
      cnt_r      <= cnt_r + CW'(1);
      frame_done <= 1'b0;
    end
  end

  // Next display outputs; segments are also dark during the anti-ghost blank
  always_comb begin
    units_pat_s = seg_pattern(shadow_u_r);
    tens_pat_s  = tens_pattern(shadow_t_r);
    seg_s       = SEG_XOR;
    an_s        = AN_XOR;
    dp_s        = DP_XOR;
    if (en && (cnt_r >= BLANK_END)) begin
      if (!slot_r) begin
        an_s  = 2'b01 ^ AN_XOR;
        seg_s = units_pat_s ^ SEG_XOR;
        dp_s  = hold ^ DP_XOR;
      end else begin
        an_s  = 2'b10 ^ AN_XOR;
        seg_s = tens_pat_s ^ SEG_XOR;
        dp_s  = DP_XOR;
      end
    end else begin
      seg_s = SEG_XOR;
      an_s  = AN_XOR;
      dp_s  = DP_XOR;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_XOR;
      an  <= AN_XOR;
      dp  <= DP_XOR;
    end else begin
      seg <= seg_s;
      an  <= an_s;
      dp  <= dp_s;
    end
  end

endmodule
